// File: rtl/pixel_band_streamer_pkg.sv
// Shared constants for the pixel band streamer: default pixel width,
// FSM state encoding and the padding value used around the frame.
package pixel_band_streamer_pkg;

  localparam int unsigned PIX_W_DEF = 5;
  localparam int unsigned ST_W      = 3;
  localparam int unsigned PAD_PIX   = 0;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_PRIME  = 3'd1;
  localparam logic [ST_W-1:0] ST_STREAM = 3'd2;
  localparam logic [ST_W-1:0] ST_GAP    = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/pixel_band_streamer_line_buffer.sv
// One image row of pixels: single write port, asynchronous read port.
module pixel_line_buffer
  import pixel_band_streamer_pkg::*;
#(
  parameter int unsigned WIDTH = 100,
  parameter int unsigned PIX_W = PIX_W_DEF,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] line_q [WIDTH];

  // Contents are don't-care after reset, so the array has no reset.
  always_ff @(posedge clk) begin
    if (we) line_q[waddr] <= wdata;
  end

  assign rdata = line_q[raddr];

endmodule

// File: rtl/pixel_band_streamer.sv
// Streams a stored frame from pixel SRAM as zero-padded vertical 3-pixel
// column triples, one band per image row, reading each pixel exactly once.
module pixel_band_streamer
  import pixel_band_streamer_pkg::*;
#(
  parameter int unsigned WIDTH    = 100,
  parameter int unsigned HEIGHT   = 100,
  parameter int unsigned PIX_W    = PIX_W_DEF,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned BAND_GAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_in,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              mode,
  output logic [PIX_W-1:0]  pixel_in0,
  output logic [PIX_W-1:0]  pixel_in1,
  output logic [PIX_W-1:0]  pixel_in2,
  output logic              load_end,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned COL_W = $clog2(WIDTH + 4);
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [COL_W-1:0] PRIME_END = COL_W'(WIDTH - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(WIDTH + 1);
  localparam logic [COL_W-1:0] DRAIN_COL = COL_W'(WIDTH + 3);
  localparam logic [COL_W-1:0] DATA_END  = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(HEIGHT - 1);
  localparam logic [2:0]       GAP_END   = 3'((BAND_GAP == 0) ? 0 : BAND_GAP - 1);
  localparam logic [PIX_W-1:0] PAD       = PIX_W'(PAD_PIX);

  logic [ST_W-1:0]   state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [2:0]        gap_q, gap_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_base;
  logic              mem_ren_q, mem_ren_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mode_q, mode_d;
  logic              role_q, role_d;
  logic              top_zero_q, top_zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, rd_next;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_prime_q, s1_prime_d;
  logic              s1_pad_q, s1_pad_d;
  logic              s1_last_q, s1_last_d;
  logic              s1_botz_q, s1_botz_d;
  logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;

  logic [PIX_W-1:0]  pix0_q, pix0_d, pix1_q, pix1_d, pix2_q, pix2_d;
  logic              out_valid_q, out_valid_d;
  logic              load_end_q, load_end_d;

  logic              live, fill_top, we_a, we_b;
  logic [PIX_W-1:0]  rd_a, rd_b, top_rd, mid_rd;

  // Control: FSM, counters and the read issued for the next cycle.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    accept   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_PRIME;
          col_d   = '0;
          row_d   = '0;
          mode_d  = mode_in;
        end
      end
      ST_PRIME: begin
        if (col_q == PRIME_END) begin
          state_d = ST_STREAM;
          col_d   = '0;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      ST_STREAM: begin
        // The last band runs two extra columns so done follows the pipe.
        if (row_q == LAST_ROW) begin
          if (col_q == DRAIN_COL) state_d = ST_DONE;
          else                    col_d   = col_q + COL_W'(1);
        end else if (col_q == LAST_COL) begin
          if (BAND_GAP == 0) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_END) begin
          state_d = ST_STREAM;
          col_d   = '0;
          row_d   = row_q + ROW_W'(1);
        end else begin
          gap_d = gap_q + 3'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    rd_next = (state_d == ST_PRIME) ||
              ((state_d == ST_STREAM) && (col_d != '0) && (col_d <= DATA_END) &&
               (row_d != LAST_ROW));
    ptr_base   = accept ? '0 : ptr_q;
    mem_ren_d  = rd_next;
    mem_addr_d = rd_next ? ptr_base : '0;
    ptr_d      = rd_next ? ptr_base + ADDR_W'(1) : ptr_base;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // Datapath: stage 1 tags the column, stage 2 assembles the triple.
  always_comb begin
    s1_valid_d = (state_q == ST_STREAM) && (col_q <= LAST_COL);
    s1_prime_d = (state_q == ST_PRIME);
    s1_pad_d   = (col_q == '0) || (col_q == LAST_COL);
    s1_last_d  = (col_q == LAST_COL);
    s1_botz_d  = (row_q == LAST_ROW);
    s1_idx_d   = (state_q == ST_PRIME) ? IDX_W'(col_q) : IDX_W'(col_q - COL_W'(1));

    top_rd   = role_q ? rd_b : rd_a;
    mid_rd   = role_q ? rd_a : rd_b;
    live     = s1_valid_q && !s1_pad_q;
    fill_top = live && !s1_botz_q;
    we_a     = s1_prime_q ? role_q  : (fill_top && !role_q);
    we_b     = s1_prime_q ? !role_q : (fill_top && role_q);

    pix0_d      = (live && !top_zero_q) ? top_rd : PAD;
    pix1_d      = live ? mid_rd : PAD;
    pix2_d      = fill_top ? mem_rdata : PAD;
    out_valid_d = s1_valid_q;
    load_end_d  = s1_valid_q && s1_last_q;

    role_d     = role_q;
    top_zero_d = top_zero_q;
    if (accept) begin
      role_d     = 1'b0;
      top_zero_d = 1'b1;
    end else if (load_end_d) begin
      role_d     = !role_q;
      top_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      gap_q       <= '0;
      ptr_q       <= '0;
      mem_ren_q   <= 1'b0;
      mem_addr_q  <= '0;
      mode_q      <= 1'b0;
      role_q      <= 1'b0;
      top_zero_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_prime_q  <= 1'b0;
      s1_pad_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_botz_q   <= 1'b0;
      s1_idx_q    <= '0;
      pix0_q      <= '0;
      pix1_q      <= '0;
      pix2_q      <= '0;
      out_valid_q <= 1'b0;
      load_end_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      gap_q       <= gap_d;
      ptr_q       <= ptr_d;
      mem_ren_q   <= mem_ren_d;
      mem_addr_q  <= mem_addr_d;
      mode_q      <= mode_d;
      role_q      <= role_d;
      top_zero_q  <= top_zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_prime_q  <= s1_prime_d;
      s1_pad_q    <= s1_pad_d;
      s1_last_q   <= s1_last_d;
      s1_botz_q   <= s1_botz_d;
      s1_idx_q    <= s1_idx_d;
      pix0_q      <= pix0_d;
      pix1_q      <= pix1_d;
      pix2_q      <= pix2_d;
      out_valid_q <= out_valid_d;
      load_end_q  <= load_end_d;
    end
  end

  pixel_line_buffer #(.WIDTH(WIDTH), .PIX_W(PIX_W), .IDX_W(IDX_W)) u_buf_a (
    .clk   (clk),
    .we    (we_a),
    .waddr (s1_idx_q),
    .wdata (mem_rdata),
    .raddr (s1_idx_q),
    .rdata (rd_a)
  );

  pixel_line_buffer #(.WIDTH(WIDTH), .PIX_W(PIX_W), .IDX_W(IDX_W)) u_buf_b (
    .clk   (clk),
    .we    (we_b),
    .waddr (s1_idx_q),
    .wdata (mem_rdata),
    .raddr (s1_idx_q),
    .rdata (rd_b)
  );

  assign mem_ren   = mem_ren_q;
  assign mem_addr  = mem_addr_q;
  assign mode      = mode_q;
  assign pixel_in0 = pix0_q;
  assign pixel_in1 = pix1_q;
  assign pixel_in2 = pix2_q;
  assign load_end  = load_end_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pixel_band_streamer.sv
// Directed bench: 4x3 frames with band gaps of 2 and 0, plus a full
// 100x100 random frame checked against a padded-window model.
module tb_pixel_band_streamer;

  localparam int unsigned PW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, mode_in;

  logic          ren_a, ren_b, ren_c;
  logic [3:0]    addr_a, addr_b;
  logic [13:0]   addr_c;
  logic [PW-1:0] rdata_a, rdata_b, rdata_c;
  logic          mode_a, mode_b, mode_c;
  logic [PW-1:0] p0_a, p1_a, p2_a, p0_b, p1_b, p2_b, p0_c, p1_c, p2_c;
  logic          le_a, le_b, le_c, ov_a, ov_b, ov_c;
  logic          busy_a, busy_b, busy_c, done_a, done_b, done_c;

  logic [PW-1:0] mem_s [16];
  logic [PW-1:0] mem_c [16384];

  always @(posedge clk) begin
    if (ren_a) rdata_a <= mem_s[addr_a];
    if (ren_b) rdata_b <= mem_s[addr_b];
    if (ren_c) rdata_c <= mem_c[addr_c];
  end

  pixel_band_streamer #(.WIDTH(4), .HEIGHT(3), .PIX_W(PW), .ADDR_W(4), .BAND_GAP(2)) dut_a (
    .clk(clk), .reset(rst_n), .start(start), .mode_in(mode_in),
    .mem_ren(ren_a), .mem_addr(addr_a), .mem_rdata(rdata_a), .mode(mode_a),
    .pixel_in0(p0_a), .pixel_in1(p1_a), .pixel_in2(p2_a),
    .load_end(le_a), .out_valid(ov_a), .busy(busy_a), .done(done_a));

  pixel_band_streamer #(.WIDTH(4), .HEIGHT(3), .PIX_W(PW), .ADDR_W(4), .BAND_GAP(0)) dut_b (
    .clk(clk), .reset(rst_n), .start(start), .mode_in(mode_in),
    .mem_ren(ren_b), .mem_addr(addr_b), .mem_rdata(rdata_b), .mode(mode_b),
    .pixel_in0(p0_b), .pixel_in1(p1_b), .pixel_in2(p2_b),
    .load_end(le_b), .out_valid(ov_b), .busy(busy_b), .done(done_b));

  pixel_band_streamer #(.WIDTH(100), .HEIGHT(100), .PIX_W(PW), .ADDR_W(14), .BAND_GAP(1)) dut_c (
    .clk(clk), .reset(rst_n), .start(start), .mode_in(mode_in),
    .mem_ren(ren_c), .mem_addr(addr_c), .mem_rdata(rdata_c), .mode(mode_c),
    .pixel_in0(p0_c), .pixel_in1(p1_c), .pixel_in2(p2_c),
    .load_end(le_c), .out_valid(ov_c), .busy(busy_c), .done(done_c));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input bit big, input int r, input int c);
    int w, h;
    w = big ? 100 : 4;
    h = big ? 100 : 3;
    if (r < 0 || r >= h || c < 0 || c >= w) return '0;
    return big ? mem_c[r*w + c] : mem_s[r*w + c];
  endfunction

  function automatic logic [14:0] trip(input bit big, input int r, input int p);
    return {pix(big, r-1, p-1), pix(big, r, p-1), pix(big, r+1, p-1)};
  endfunction

  logic [14:0] a_trip [18];
  logic [14:0] band0_exp [6];

  initial begin
    int a_first, a_first_le, a_last_le, a_le_n, a_ov_n, a_reads, a_b2_reads;
    int a_done_cyc, a_done_n, a_mode_bad, a_low;
    int b_ov_n, b_low, b_le_n, b_done_cyc;
    int c_k, c_le_n, c_reads;
    bit c_done_seen;

    a_first = -1; a_first_le = -1; a_last_le = -1; a_le_n = 0; a_ov_n = 0;
    a_reads = 0; a_b2_reads = 0; a_done_cyc = -1; a_done_n = 0; a_mode_bad = 0; a_low = 0;
    b_ov_n = 0; b_low = 0; b_le_n = 0; b_done_cyc = -1;
    c_k = 0; c_le_n = 0; c_reads = 0; c_done_seen = 0;

    band0_exp[0] = {5'd0, 5'd0, 5'd0};
    band0_exp[1] = {5'd0, 5'd1, 5'd5};
    band0_exp[2] = {5'd0, 5'd2, 5'd6};
    band0_exp[3] = {5'd0, 5'd3, 5'd7};
    band0_exp[4] = {5'd0, 5'd4, 5'd8};
    band0_exp[5] = {5'd0, 5'd0, 5'd0};

    for (int i = 0; i < 16; i++) mem_s[i] = (i < 12) ? PW'(i + 1) : '0;
    for (int i = 0; i < 16384; i++) mem_c[i] = PW'($urandom_range(0, 31));

    rst_n = 1'b0; start = 1'b0; mode_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_ren", 32'(ren_a), 0);
    check("rst_mem_addr", 32'(addr_a), 0);
    check("rst_out_valid", 32'(ov_a), 0);
    check("rst_busy_done", 32'({busy_a, done_a, busy_c, done_c}), 0);
    check("rst_mode_le", 32'({mode_a, le_a}), 0);
    check("rst_pixels", 32'({p0_a, p1_a, p2_a}), 0);

    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; mode_in = 1'b1;
    @(negedge clk);

    // Sample index 1 is the first cycle after the accepting edge.
    for (int cyc = 1; cyc <= 12000 && !c_done_seen; cyc++) begin
      start   = (cyc == 3) || (cyc == 16);
      mode_in = 1'b0;

      if (ren_a) begin
        a_reads++;
        if (a_le_n == 2) a_b2_reads++;
      end
      if (busy_a && !mode_a) a_mode_bad++;
      if (ov_a) begin
        if (a_first < 0) a_first = cyc;
        if (a_ov_n < 18) a_trip[a_ov_n] = {p0_a, p1_a, p2_a};
        a_ov_n++;
      end else if (a_first > 0 && a_le_n > 0 && a_le_n < 3) begin
        a_low++;
      end
      if (le_a) begin
        if (a_first_le < 0) a_first_le = cyc;
        a_last_le = cyc;
        a_le_n++;
      end
      if (done_a) begin
        a_done_cyc = cyc;
        a_done_n++;
      end

      if (ov_b) b_ov_n++;
      else if (b_le_n > 0 && b_le_n < 3) b_low++;
      if (le_b) b_le_n++;
      if (done_b) b_done_cyc = cyc;

      if (ov_c) begin
        check("big_triple", 32'({p0_c, p1_c, p2_c}), 32'(trip(1'b1, c_k / 102, c_k % 102)));
        c_k++;
      end
      if (le_c) c_le_n++;
      if (ren_c) c_reads++;
      if (done_c) c_done_seen = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;

    for (int i = 0; i < 6; i++) check("small_band0_col", 32'(a_trip[i]), 32'(band0_exp[i]));
    check("small_b1_p2", 32'(a_trip[8]), 32'({5'd2, 5'd6, 5'd10}));
    check("small_b2_p2", 32'(a_trip[14]), 32'({5'd6, 5'd10, 5'd0}));
    for (int i = 0; i < 18; i++) check("small_model", 32'(a_trip[i]), 32'(trip(1'b0, i / 6, i % 6)));
    check("small_first_valid", 32'(a_first), 7);
    check("small_first_le", 32'(a_first_le), 12);
    check("small_le_count", 32'(a_le_n), 3);
    check("small_ov_count", 32'(a_ov_n), 18);
    check("small_reads", 32'(a_reads), 12);
    check("small_b2_reads", 32'(a_b2_reads), 0);
    check("small_last_le", 32'(a_last_le), 28);
    check("small_done_cyc", 32'(a_done_cyc), 29);
    check("small_done_pulses", 32'(a_done_n), 1);
    check("small_mode_held", 32'(a_mode_bad), 0);
    check("mode_after_frame", 32'(mode_a), 1);
    check("gap2_low_cycles", 32'(a_low), 4);
    check("gap0_low_cycles", 32'(b_low), 0);
    check("gap0_ov_count", 32'(b_ov_n), 18);
    check("gap0_done_cyc", 32'(b_done_cyc), 25);
    check("big_done_seen", 32'(c_done_seen), 1);
    check("big_ov_count", 32'(c_k), 10200);
    check("big_le_count", 32'(c_le_n), 100);
    check("big_reads", 32'(c_reads), 10000);

    // Mid-frame reset, then restart from row 0.
    start = 1'b1; mode_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !ov_a; i++) @(negedge clk);
    check("midrst_reached_stream", 32'(ov_a), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({ren_a, addr_a, mode_a, le_a, ov_a, busy_a, done_a}), 0);
    check("midrst_pixels", 32'({p0_a, p1_a, p2_a}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_first_read", 32'({ren_a, addr_a, busy_a}), 32'({1'b1, 4'd0, 1'b1}));
    @(negedge clk);
    check("restart_second_read", 32'({ren_a, addr_a}), 32'({1'b1, 4'd1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_band_streamer.md
Name: pixel_band_streamer

Overview:
- Transmit-side source for the edge/pixel processing CHIP. Reads a stored frame from a synchronous single-port pixel SRAM and drives the CHIP's three-row input interface.
- Per band (one per image row), it emits WIDTH+2 columns of vertical 3-pixel triples, zero-padded on all sides. load_end is asserted on each band's last column.
- Two internal line buffers mean every frame pixel is read from memory exactly once.

Parameters:
- WIDTH, 100: image columns, unpadded.
- HEIGHT, 100: image rows, unpadded.
- PIX_W, 5: pixel width in bits.
- ADDR_W, 14: SRAM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- BAND_GAP, 1: idle cycles between bands, with out_valid low. Range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- mode_in  in  1  processing mode, sampled on an accepted start.
- mem_ren  out  1  SRAM read enable.
- mem_addr  out  ADDR_W  SRAM address = row*WIDTH + col.
- mem_rdata  in  PIX_W  SRAM data, valid 1 cycle after mem_ren.
- mode  out  1  latched mode_in, held for the whole frame.
- pixel_in0  out  PIX_W  top row (r-1) pixel.
- pixel_in1  out  PIX_W  centre row (r) pixel.
- pixel_in2  out  PIX_W  bottom row (r+1) pixel.
- load_end  out  1  high with the last column (col WIDTH+1) of every band.
- out_valid  out  1  pixel_in0..2 carry a valid column.
- busy  out  1  high from accepted start until the done pulse.
- done  out  1  one-cycle pulse after the final column of band HEIGHT-1.

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; line-buffer contents don't-care; zero-flag set.
- States:
  - IDLE -> PRIME on start.
  - PRIME: reads row 0, cols 0..WIDTH-1, one per cycle, into buffer MID. Then -> STREAM.
  - STREAM: WIDTH+2 column cycles for band r. Then -> GAP, or -> DONE if r == HEIGHT-1. If BAND_GAP=0, skip GAP.
  - GAP: holds BAND_GAP cycles -> STREAM(r+1).
  - DONE: 1 cycle, done=1 -> IDLE.
- start is ignored unless in IDLE. mode_in is latched only on an accepted start. mode stays stable until the next accepted start.
- Column sourcing in band r, padded column p = 0..WIDTH+1:
  - p=0 and p=WIDTH+1: output triple (0,0,0); no SRAM read.
  - Otherwise c = p-1.
  - pixel_in0 = TOP[c], or 0 when r=0.
  - pixel_in1 = MID[c].
  - pixel_in2 = mem[(r+1)*WIDTH + c], or 0 with no read when r = HEIGHT-1.
- Buffer update: in the cycle TOP[c] is consumed, TOP[c] is overwritten with the bottom pixel. At band end the roles of TOP and MID swap (role bit toggles), and the zero-flag for TOP clears after band 0.
- Latency:
  - Address issued in cycle t; mem_rdata captured at t+1; output registered at t+2.
  - The first out_valid of each band is 2 cycles after STREAM entry.
  - Columns are then emitted back-to-back, WIDTH+2 consecutive out_valid cycles per band. No bubbles inside a band.
- Padding columns travel through the same 2-stage pipe, so column order and latency are uniform.
- PRIME reads produce no out_valid.
- Arithmetic: row*WIDTH is computed incrementally as a running base address (+WIDTH per row); no multiplier. Column and row counters wrap only via explicit state transitions.
- Totals per frame:
  - out_valid cycles = HEIGHT*(WIDTH+2).
  - load_end pulses = HEIGHT.
  - SRAM reads = WIDTH*HEIGHT.
- Reset asserted mid-frame: immediate return to IDLE with outputs 0. No partial done. The next start re-primes from row 0.
- start coincident with the done cycle is ignored.

Decomposition:
- Shared package: PIX_W default, state encoding (IDLE, PRIME, STREAM, GAP, DONE), padding value 0.
- One sub-module, pixel_line_buffer: a WIDTH x PIX_W register array with 1 write and 1 async read port, instantiated twice.
- FSM, counters and output pipe stay in the top level.

Test Plan:
- Reset: reset low mid-STREAM -> all outputs 0 within the same cycle; start after release -> PRIME restarts at mem_addr=0.
- Small frame, WIDTH=4, HEIGHT=3, mem[i]=i+1:
  - Band 0 columns: (0,0,0), (0,1,5), (0,2,6), (0,3,7), (0,4,8), (0,0,0); load_end on the 6th.
- Same frame, bands 1 and 2:
  - Band 1 col p=2 -> (2,6,10).
  - Band 2 col p=2 -> (6,10,0).
  - Band 2 reads 0 SRAM addresses.
  - done 1 cycle after the last load_end.
  - Total out_valid = 18, SRAM reads = 12.
- Timing: first out_valid exactly 2 cycles after STREAM entry; BAND_GAP=2 gives exactly 2 out_valid-low cycles between bands; BAND_GAP=0 gives none.
- Handshake: start pulses while busy -> ignored. mode_in=1 at start and 0 afterwards -> mode stays 1 all frame.
- Full default size, 100x100, random memory: scoreboard compares every triple against a software padded-window model; 10200 out_valid cycles, 100 load_end pulses.
